pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Program-counter sequencer for a simple pipelined core. A small control FSM
//   decides whether the PC may advance: continuously (RUN), exactly once
//   (STEP), not at all (IDLE), or never again until reset (HALT). When the PC
//   advances, the next value is chosen by priority: jump target, then branch
//   target, then PC+4. Taken jumps and branches also request a flush of the
//   IF/ID stage.
//
// Optional feature:
//   Define PC_SEQ_CYCLE_COUNT_EN to add o_CycleCount. This is a saturating
//   32-bit count of the cycles in which the PC advanced. When the macro is not
//   defined, the port and the counter are not built.
//
// Parameters:
//   NBITS     width of the PC and of the target addresses (minimum 3)
//   RESET_PC  PC value loaded while reset is asserted
//
// Ports:
//   i_clk         clock; all state updates on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_Start       level: leave IDLE and run continuously
//   i_Step        pulse: leave IDLE and advance the PC exactly once
//   i_Halt        HALT instruction decoded this cycle
//   i_Stall       hazard stall: hold the PC this cycle
//   i_Jump        jump taken
//   i_PCSrc       branch taken
//   i_JumpAddr    jump target
//   i_BranchAddr  branch target
//   o_PC          registered current PC
//   o_PCWrite     high in the cycles where the PC advances
//   o_Flush       flush IF/ID on a taken jump or branch
//   o_State       FSM state register
//   o_Halted      high while in HALT
//   o_CycleCount  (PC_SEQ_CYCLE_COUNT_EN only) number of PC advances
//
// State table:
//   state | meaning
//   IDLE  | PC held; waiting for i_Start or i_Step
//   RUN   | PC advances every cycle that is not stalled or halted
//   STEP  | one advance pending; a stall keeps us here until it happens
//   HALT  | sticky; PC frozen and all inputs ignored until reset
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int               NBITS    = 32,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_Start,
  input  logic             i_Step,
  input  logic             i_Halt,
  input  logic             i_Stall,
  input  logic             i_Jump,
  input  logic             i_PCSrc,
  input  logic [NBITS-1:0] i_JumpAddr,
  input  logic [NBITS-1:0] i_BranchAddr,
  output logic [NBITS-1:0] o_PC,
  output logic             o_PCWrite,
  output logic             o_Flush,
  output logic [1:0]       o_State,
  output logic             o_Halted
`ifdef PC_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]      o_CycleCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_pc;
  logic [NBITS-1:0] w_pc_nxt;
  logic [NBITS-1:0] w_pc_plus4;
  logic [NBITS-1:0] w_jump_aligned;
  logic [NBITS-1:0] w_branch_aligned;
  logic             w_pc_write;
  logic             w_flush;
  logic             w_halted;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // i_Halt is only meaningful once instructions are flowing, so IDLE ignores
  // it. In RUN and STEP it overrides stall, jump and branch.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_state_nxt = S_RUN;
        end else if (i_Step) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN: begin
        if (i_Halt) begin
          w_state_nxt = S_HALT;
        end
      end
      S_STEP: begin
        if (i_Halt) begin
          w_state_nxt = S_HALT;
        end else if (!i_Stall) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // The PC may advance only in RUN or STEP. Reset forces the state to IDLE,
  // so o_PCWrite and o_Flush drop to 0 as soon as reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pc_write = 1'b0;
    w_halted   = 1'b0;
    case (r_state)
      S_RUN,
      S_STEP: w_pc_write = ~i_Stall & ~i_Halt;
      S_HALT: w_halted   = 1'b1;
      default: begin
        w_pc_write = 1'b0;
        w_halted   = 1'b0;
      end
    endcase
    w_flush = w_pc_write & (i_Jump | i_PCSrc);
  end

  // ---------------------------------------------------------------------------
  // Next-PC datapath
  // Targets are forced to word alignment. PC+4 wraps naturally at the
  // register width.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_jump_aligned   = {i_JumpAddr[NBITS-1:2], 2'b00};
    w_branch_aligned = {i_BranchAddr[NBITS-1:2], 2'b00};
    w_pc_plus4       = r_pc + NBITS'(4);
    if (i_Jump) begin
      w_pc_nxt = w_jump_aligned;
    end else if (i_PCSrc) begin
      w_pc_nxt = w_branch_aligned;
    end else begin
      w_pc_nxt = w_pc_plus4;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= RESET_PC;
    end else if (w_pc_write) begin
      r_pc <= w_pc_nxt;
    end
  end

`ifdef PC_SEQ_CYCLE_COUNT_EN
  // ---------------------------------------------------------------------------
  // Advance counter. It saturates rather than wraps, so that a long run
  // cannot be mistaken for a short one.
  // ---------------------------------------------------------------------------
  logic [31:0] r_cycle_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycle_count <= '0;
    end else if (w_pc_write && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign o_CycleCount = r_cycle_count;
`endif

  assign o_PC      = r_pc;
  assign o_PCWrite = w_pc_write;
  assign o_Flush   = w_flush;
  assign o_State   = r_state;
  assign o_Halted  = w_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer with default parameters (NBITS=32,
// RESET_PC=0). Inputs change 1 ns after a rising edge. Registered outputs are
// sampled at that same point, and combinational outputs are sampled 1 ns after
// the inputs change. Define PC_SEQ_CYCLE_COUNT_EN to build and check the
// advance counter.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_Start;
  logic        i_Step;
  logic        i_Halt;
  logic        i_Stall;
  logic        i_Jump;
  logic        i_PCSrc;
  logic [31:0] i_JumpAddr;
  logic [31:0] i_BranchAddr;
  logic [31:0] o_PC;
  logic        o_PCWrite;
  logic        o_Flush;
  logic [1:0]  o_State;
  logic        o_Halted;
`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [31:0] o_CycleCount;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  pc_sequencer #(.NBITS(32), .RESET_PC(32'h0)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_Start      (i_Start),
    .i_Step       (i_Step),
    .i_Halt       (i_Halt),
    .i_Stall      (i_Stall),
    .i_Jump       (i_Jump),
    .i_PCSrc      (i_PCSrc),
    .i_JumpAddr   (i_JumpAddr),
    .i_BranchAddr (i_BranchAddr),
    .o_PC         (o_PC),
    .o_PCWrite    (o_PCWrite),
    .o_Flush      (o_Flush),
    .o_State      (o_State),
    .o_Halted     (o_Halted)
`ifdef PC_SEQ_CYCLE_COUNT_EN
    ,
    .o_CycleCount (o_CycleCount)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PC_SEQ_CYCLE_COUNT_EN
    chk(tag, o_CycleCount, 32'(exp_cnt));
`endif
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_Start      = 1'b0;
    i_Step       = 1'b0;
    i_Halt       = 1'b0;
    i_Stall      = 1'b0;
    i_Jump       = 1'b0;
    i_PCSrc      = 1'b0;
    i_JumpAddr   = 32'h0;
    i_BranchAddr = 32'h0;
    #2;
    chk("rst_pc",      o_PC,      32'h0);
    chk("rst_state",   o_State,   32'h0);
    chk("rst_pcwrite", o_PCWrite, 32'h0);
    chk("rst_flush",   o_Flush,   32'h0);
    chk("rst_halted",  o_Halted,  32'h0);
    chk_cnt("rst_cnt");

    @(negedge i_clk);
    i_reset_n = 1'b1;
    step_clk();
    chk("idle_hold_pc",    o_PC,    32'h0);
    chk("idle_hold_state", o_State, 32'h0);

    // Start from IDLE: the entry edge itself does not advance the PC.
    i_Start = 1'b1;
    step_clk();
    chk("run_entry_state", o_State,   32'h1);
    chk("run_entry_pc",    o_PC,      32'h0);
    chk("run_entry_pcw",   o_PCWrite, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step_clk();
      exp_cnt++;
      chk($sformatf("run_pc_%0d", i), o_PC,      32'(4 * i));
      chk($sformatf("run_pcw_%0d", i), o_PCWrite, 32'h1);
    end
    i_Start = 1'b0;
    chk_cnt("run_cnt");

    // Jump beats branch, and the target is forced to word alignment.
    i_Jump       = 1'b1;
    i_PCSrc      = 1'b1;
    i_JumpAddr   = 32'h43;
    i_BranchAddr = 32'h80;
    #1;
    chk("jmp_flush", o_Flush,   32'h1);
    chk("jmp_pcw",   o_PCWrite, 32'h1);
    step_clk();
    exp_cnt++;
    chk("jmp_pc", o_PC, 32'h40);

    // Branch only, with an unaligned target.
    i_Jump       = 1'b0;
    i_BranchAddr = 32'h81;
    #1;
    chk("br_flush", o_Flush, 32'h1);
    step_clk();
    exp_cnt++;
    chk("br_pc", o_PC, 32'h80);

    // A stall holds the PC and suppresses the flush despite a taken branch.
    i_Stall = 1'b1;
    #1;
    chk("stall_pcw",   o_PCWrite, 32'h0);
    chk("stall_flush", o_Flush,   32'h0);
    step_clk();
    chk("stall_pc",    o_PC,      32'h80);
    chk("stall_state", o_State,   32'h1);

    i_Stall = 1'b0;
    i_PCSrc = 1'b0;
    #1;
    chk("seq_flush", o_Flush, 32'h0);
    step_clk();
    exp_cnt++;
    chk("seq_pc", o_PC, 32'h84);

    // Wrap: jump to the top word, then PC+4 wraps to 0.
    i_Jump     = 1'b1;
    i_JumpAddr = 32'hFFFF_FFFF;
    step_clk();
    exp_cnt++;
    chk("top_pc", o_PC, 32'hFFFF_FFFC);
    chk_cnt("top_cnt");
    i_Jump = 1'b0;
    step_clk();
    exp_cnt++;
    chk("wrap_pc", o_PC, 32'h0);
    chk_cnt("wrap_cnt");
    step_clk();
    exp_cnt++;
    chk("post_wrap_pc", o_PC, 32'h4);

    // Asynchronous reset in mid-cycle during RUN.
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_pc",    o_PC,      32'h0);
    chk("mid_rst_state", o_State,   32'h0);
    chk("mid_rst_pcw",   o_PCWrite, 32'h0);
    chk_cnt("mid_rst_cnt");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step_clk();
    chk("rel_pc",    o_PC,    32'h0);
    chk("rel_state", o_State, 32'h0);

    // Single step with a stall: the PC is held for 2 cycles, then advances once.
    i_Step  = 1'b1;
    i_Stall = 1'b1;
    step_clk();
    i_Step = 1'b0;
    chk("step_state1", o_State,   32'h2);
    chk("step_pc1",    o_PC,      32'h0);
    chk("step_pcw1",   o_PCWrite, 32'h0);
    step_clk();
    chk("step_state2", o_State, 32'h2);
    chk("step_pc2",    o_PC,    32'h0);
    i_Stall = 1'b0;
    #1;
    chk("step_pcw3", o_PCWrite, 32'h1);
    step_clk();
    exp_cnt++;
    chk("step_pc3",    o_PC,    32'h4);
    chk("step_state3", o_State, 32'h0);
    chk_cnt("step_cnt");
    step_clk();
    chk("step_idle_pc", o_PC, 32'h4);

    // Start and Step together: Start wins.
    i_Start = 1'b1;
    i_Step  = 1'b1;
    step_clk();
    i_Start = 1'b0;
    i_Step  = 1'b0;
    chk("both_state", o_State, 32'h1);

    // Halt beats jump and freezes the PC; the HALT state is sticky.
    i_Halt     = 1'b1;
    i_Jump     = 1'b1;
    i_JumpAddr = 32'h200;
    #1;
    chk("halt_pcw",   o_PCWrite, 32'h0);
    chk("halt_flush", o_Flush,   32'h0);
    step_clk();
    chk("halt_pc",     o_PC,     32'h4);
    chk("halt_halted", o_Halted, 32'h1);
    chk("halt_state",  o_State,  32'h3);
    i_Halt  = 1'b0;
    i_Start = 1'b1;
    step_clk();
    step_clk();
    chk("halt_sticky_pc",    o_PC,      32'h4);
    chk("halt_sticky_state", o_State,   32'h3);
    chk("halt_sticky_pcw",   o_PCWrite, 32'h0);
    chk("halt_sticky_flush", o_Flush,   32'h0);
    chk_cnt("halt_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
